key_click_decoder: RTL and testbench
====================================

Name: key_click_decoder

Overview:
- Sits directly downstream of the key debounce stage and consumes its one-cycle `key_flag` pulse, issued about 20 ms after a stable press.
- Classifies each press gesture as a single click, a double click or (optionally) a long press.
- Emits one registered one-cycle pulse per gesture to the application logic (LED/mode control).
- Also monitors the raw active-low `key_in` to detect release and hold.

Parameters:
- CNT_WIN, 24'd14_999_999, double-click window in sys_clk cycles minus 1 (300 ms at 50 MHz), measured from the first `key_flag`.
- CNT_LONG, 26'd49_999_999, long-press hold time in cycles minus 1 (1 s at 50 MHz), measured while `key_in` stays low.

Ports:
- sys_clk  input  1  system clock, 50 MHz
- sys_rst_n  input  1  asynchronous, active-low reset
- key_in  input  1  raw key level, 0 = pressed
- key_flag  input  1  one-cycle debounced press pulse from the debounce stage
- single_click  output  1  one-cycle pulse: single click recognised
- double_click  output  1  one-cycle pulse: double click recognised
- long_press  output  1  one-cycle pulse: long press recognised (tied 0 without LONG_PRESS_EN)
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (asynchronous, `sys_rst_n`=0):
  - state=IDLE; win_cnt=0; long_cnt=0.
  - single_click=0, double_click=0, long_press=0, busy=0.
  - Reset mid-gesture aborts it; no pulse is emitted.
- Output timing:
  - All outputs are registered.
  - A pulse is high for exactly one cycle, in the cycle after the triggering condition is sampled.
  - At most one output pulses per gesture.
- win_cnt:
  - Clears on entry to FIRST.
  - Increments each cycle in FIRST.
  - Expiry is `win_cnt == CNT_WIN`.
- long_cnt:
  - Cleared whenever `key_in` is 1.
  - Otherwise increments, saturating at CNT_LONG.
  - Unsigned arithmetic, no wrap.
- State IDLE:
  - `key_flag`=1 -> FIRST.
  - `key_in` alone is ignored.
- State FIRST:
  - `key_flag`=1 -> double_click pulse, go to IDLE.
  - Else, at window expiry:
    - with `key_in`=1 -> single_click pulse, go to IDLE;
    - with `key_in`=0 -> PRESS (LONG_PRESS_EN only; otherwise single_click pulse, go to IDLE).
  - If `key_flag` and window expiry occur in the same cycle, `key_flag` wins and the gesture is a double click.
- State PRESS (LONG_PRESS_EN only):
  - `key_in`=1 -> single_click pulse, go to IDLE.
  - `long_cnt == CNT_LONG` -> long_press pulse, go to HELD.
  - If both happen in the same cycle, release wins.
- State HELD:
  - Wait for `key_in`=1, then go to IDLE.
  - Nothing is emitted.
- `key_flag` in PRESS or HELD is ignored: no pulse, no state change.
- Back-to-back gestures: a `key_flag` arriving in the same cycle the FSM returns to IDLE is not seen; it must arrive in IDLE.
- Encoding: state register 2 bits. Illegal encodings recover to IDLE on the next clock.

Optional Feature:
- Macro: LONG_PRESS_EN.
- Defined:
  - PRESS and HELD states and long_cnt are built.
  - long_press functions as described above.
- Undefined:
  - long_cnt, PRESS and HELD are not synthesised.
  - long_press is tied to 0.
  - Window expiry in FIRST always produces single_click, regardless of `key_in`.

Test Plan (bench overrides CNT_WIN=100, CNT_LONG=300):
- Reset check: assert `sys_rst_n`=0 with random `key_in`/`key_flag` -> all outputs 0, busy=0; release reset -> still 0 until the first `key_flag`.
- Single click: `key_flag` at cycle 10, `key_in` high from cycle 20 -> single_click high for exactly 1 cycle at cycle 112; no other pulse; busy low from cycle 112.
- Double click: `key_flag` at cycle 10 and again at 60 -> double_click one-cycle pulse at cycle 61; no single_click follows.
- Window tie: second `key_flag` exactly on the expiry cycle (cycle 111) -> double_click at 112; single_click stays 0.
- Long press (LONG_PRESS_EN): `key_in`=0 from cycle 0, `key_flag` at 10, held through cycle 400 -> PRESS entered at 111; long_press one pulse when long_cnt reaches 300; no single_click; `key_in`=1 at 450 -> IDLE, busy low.
- Long press without LONG_PRESS_EN: same stimulus -> single_click at 112; long_press never asserts. Separately, assert reset at cycle 50 during FIRST -> no pulse emitted and the FSM restarts cleanly on the next `key_flag`.

Source files
------------

// File: rtl/key_click_decoder_if.sv
// Key gesture interface: debounced key inputs toward the decoder,
// gesture pulses and busy back to the application side.
interface key_click_decoder_if;
    logic key_in;
    logic key_flag;
    logic single_click;
    logic double_click;
    logic long_press;
    logic busy;

    modport master (
        output key_in,
        output key_flag,
        input  single_click,
        input  double_click,
        input  long_press,
        input  busy
    );

    modport slave (
        input  key_in,
        input  key_flag,
        output single_click,
        output double_click,
        output long_press,
        output busy
    );
endinterface

// File: rtl/key_click_decoder.sv
// Single/double click (and long press when LONG_PRESS_EN is defined)
// classifier fed by the debounce stage's one-cycle key_flag pulse.
module key_click_decoder #(
    parameter logic [23:0] CNT_WIN  = 24'd14_999_999,
    parameter logic [25:0] CNT_LONG = 26'd49_999_999
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    key_click_decoder_if.slave kc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        PRESS = 2'd2,
        HELD  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [23:0] win_cnt;
    logic        win_end;
    logic        single_nxt;
    logic        double_nxt;
    logic        single_q;
    logic        double_q;

    assign win_end = (win_cnt == CNT_WIN);

    // held at zero outside FIRST, so it starts from zero on entry
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            win_cnt <= '0;
        else if (state != FIRST)
            win_cnt <= '0;
        else
            win_cnt <= win_cnt + 24'd1;
    end

`ifdef LONG_PRESS_EN
    logic [25:0] long_cnt;
    logic        long_end;
    logic        long_nxt;
    logic        long_q;

    assign long_end = (long_cnt == CNT_LONG);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            long_cnt <= '0;
        else if (kc.key_in)
            long_cnt <= '0;
        else if (!long_end)
            long_cnt <= long_cnt + 26'd1;
    end
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        single_nxt = 1'b0;
        double_nxt = 1'b0;
`ifdef LONG_PRESS_EN
        long_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (kc.key_flag)
                    state_nxt = FIRST;
            end
            FIRST: begin
                if (kc.key_flag) begin
                    double_nxt = 1'b1;
                    state_nxt  = IDLE;
                end else if (win_end) begin
`ifdef LONG_PRESS_EN
                    if (!kc.key_in) begin
                        state_nxt = PRESS;
                    end else begin
                        single_nxt = 1'b1;
                        state_nxt  = IDLE;
                    end
`else
                    single_nxt = 1'b1;
                    state_nxt  = IDLE;
`endif
                end
            end
`ifdef LONG_PRESS_EN
            // release beats the hold timer when both land together
            PRESS: begin
                if (kc.key_in) begin
                    single_nxt = 1'b1;
                    state_nxt  = IDLE;
                end else if (long_end) begin
                    long_nxt  = 1'b1;
                    state_nxt = HELD;
                end
            end
            HELD: begin
                if (kc.key_in)
                    state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            single_q <= 1'b0;
            double_q <= 1'b0;
        end else begin
            single_q <= single_nxt;
            double_q <= double_nxt;
        end
    end

`ifdef LONG_PRESS_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            long_q <= 1'b0;
        else
            long_q <= long_nxt;
    end

    assign kc.long_press = long_q;
`else
    assign kc.long_press = 1'b0;
`endif

    assign kc.single_click = single_q;
    assign kc.double_click = double_q;
    assign kc.busy         = (state != IDLE);

endmodule

// File: tb/tb_key_click_decoder.sv
// Directed bench for key_click_decoder (CNT_WIN=100, CNT_LONG=300);
// expectations follow LONG_PRESS_EN when it is defined.
module tb_key_click_decoder;

    logic sys_clk;
    logic sys_rst_n;

    key_click_decoder_if kif ();

    key_click_decoder #(
        .CNT_WIN  (24'd100),
        .CNT_LONG (26'd300)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .kc        (kif)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_cmp;
    int n_bad;

    int sc_n, sc_at;
    int dc_n, dc_at;
    int lp_n, lp_at;
    int busy_at, idle_at;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // reset with random inputs; outputs must read zero throughout
    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            kif.key_in   = 1'($urandom_range(0, 1));
            kif.key_flag = 1'($urandom_range(0, 1));
            #1;
            check("rst_outs", int'({kif.single_click, kif.double_click,
                                    kif.long_press, kif.busy}), 0);
            @(negedge sys_clk);
        end
        kif.key_in   = 1'b1;
        kif.key_flag = 1'b0;
        sys_rst_n    = 1'b1;
        @(posedge sys_clk);
        #1;
    endtask

    // cycle c: key_flag at f1/f2, key_in low before rel (rel<0: always high)
    task automatic run(input int f1, input int f2, input int rel,
                       input int len);
        sc_n = 0; sc_at = -1;
        dc_n = 0; dc_at = -1;
        lp_n = 0; lp_at = -1;
        busy_at = -1; idle_at = -1;
        for (int c = 0; c < len; c++) begin
            kif.key_flag = (c == f1) || (c == f2);
            kif.key_in   = (rel < 0) ? 1'b1 : (c >= rel);
            if (kif.single_click) begin
                sc_n++;
                if (sc_at < 0) sc_at = c;
            end
            if (kif.double_click) begin
                dc_n++;
                if (dc_at < 0) dc_at = c;
            end
            if (kif.long_press) begin
                lp_n++;
                if (lp_at < 0) lp_at = c;
            end
            if (kif.busy && busy_at < 0) busy_at = c;
            if (!kif.busy && busy_at >= 0 && idle_at < 0) idle_at = c;
            @(posedge sys_clk);
            #1;
        end
        kif.key_flag = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        sys_rst_n    = 1'b1;
        kif.key_in   = 1'b1;
        kif.key_flag = 1'b0;

        do_reset();
        run(-1, -1, -1, 30);
        check("idle_sc", sc_n, 0);
        check("idle_dc", dc_n, 0);
        check("idle_busy", busy_at, -1);

        do_reset();
        run(10, -1, 20, 200);
        check("single_at", sc_at, 112);
        check("single_n", sc_n, 1);
        check("single_dc", dc_n, 0);
        check("single_lp", lp_n, 0);
        check("single_busy", busy_at, 11);
        check("single_idle", idle_at, 112);

        do_reset();
        run(10, 60, -1, 200);
        check("double_at", dc_at, 61);
        check("double_n", dc_n, 1);
        check("double_sc", sc_n, 0);
        check("double_idle", idle_at, 61);

        do_reset();
        run(10, 111, -1, 200);
        check("tie_at", dc_at, 112);
        check("tie_n", dc_n, 1);
        check("tie_sc", sc_n, 0);

`ifdef LONG_PRESS_EN
        do_reset();
        run(10, 200, 450, 500);
        check("long_at", lp_at, 301);
        check("long_n", lp_n, 1);
        check("long_sc", sc_n, 0);
        check("long_dc", dc_n, 0);
        check("long_idle", idle_at, 451);
`else
        do_reset();
        run(10, -1, 450, 500);
        check("nolong_sc_at", sc_at, 112);
        check("nolong_sc_n", sc_n, 1);
        check("nolong_lp", lp_n, 0);
        check("nolong_idle", idle_at, 112);
`endif

        do_reset();
        run(10, -1, -1, 50);
        check("abort_busy", busy_at, 11);
        check("abort_pre", sc_n + dc_n + lp_n, 0);
        do_reset();
        run(-1, -1, -1, 150);
        check("abort_post", sc_n + dc_n + lp_n, 0);
        check("abort_idle", busy_at, -1);
        run(10, -1, -1, 200);
        check("restart_at", sc_at, 112);
        check("restart_n", sc_n, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
